// File: rtl/data_types_pkg.sv
// Shared types for the parameterised UART transmitter:
// control bundle, FSM state encoding and data-length clamp.
package data_types_pkg;

  localparam int CTRL_DIV_W = 16;

  typedef struct packed {
    logic [CTRL_DIV_W-1:0] br_div;
    logic [4:0]            len;
    logic                  stop;
    logic [1:0]            par;
    logic                  en;
  } tx_ctrl_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic [4:0] clamp_len(
    input logic [4:0] len,
    input int         max_w
  );
    if (int'(len) < 5) return 5'd5;
    if (int'(len) > max_w) return 5'(max_w);
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small power-of-two TX FIFO with occupancy count;
// full pushes and empty pops are ignored.
module uart_tx_fifo #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  logic [DATA_W-1:0]           i_wdata,
  input  logic                        i_pop,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// FIFO-fed UART transmitter, runtime frame format.
// Define UART_TX_PARITY_EN to build the optional parity bit.
module uart_tx_param
  import data_types_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  tx_ctrl_t                    control,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  output logic                        tx,
  output logic                        idle,
  output logic [$clog2(FIFO_DEPTH):0] level
);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  tx_state_t         r_state;
  tx_state_t         w_next;
  logic [DATA_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [4:0]        r_nd;
  logic [4:0]        r_bit;
  logic              r_stop;
  logic              r_sbit;
  logic              r_par_on;
  logic              r_par_bit;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_start;
  logic              w_div_end;
  logic              w_tx;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_mask;
  logic [4:0]        w_nd;
  logic [DIV_W-1:0]  w_div;
  logic              w_par_on;
  logic              w_par_bit;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (wr_valid),
    .i_wdata (wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign wr_ready  = !w_full;
  assign idle      = (r_state == IDLE) && w_empty;
  assign tx        = w_tx;
  assign w_start   = !w_empty && control.en;
  assign w_div_end = (r_cnt == r_div - DIV_W'(1));
  assign w_nd      = clamp_len(control.len, DATA_W);
  assign w_div     = (control.br_div == '0) ? DIV_W'(1)
                                            : DIV_W'(control.br_div);
  assign w_par_on  = PAR_EN && (control.par == 2'd1 ||
                                control.par == 2'd2);
  assign w_par_bit = (^(w_rdata & w_mask)) ^ (control.par == 2'd2);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_W; i++) w_mask[i] = (i < int'(w_nd));
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = START;
          w_pop  = 1'b1;
        end
      end
      START: if (w_div_end) w_next = DATA;
      DATA: begin
        if (w_div_end && r_bit == r_nd - 5'd1)
          w_next = r_par_on ? PARITY : STOP;
      end
      PARITY: if (w_div_end) w_next = STOP;
      STOP: begin
        if (w_div_end && r_sbit == r_stop) begin
          if (w_start) begin
            w_next = START;
            w_pop  = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_tx = 1'b1;
    unique case (r_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = r_shift[0];
      PARITY:  w_tx = r_par_bit;
      default: w_tx = 1'b1;
    endcase
  end

  // Frame format is captured at pop so control changes never reach a frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_div     <= DIV_W'(1);
      r_nd      <= 5'd5;
      r_bit     <= '0;
      r_stop    <= 1'b0;
      r_sbit    <= 1'b0;
      r_par_on  <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_shift   <= w_rdata;
        r_div     <= w_div;
        r_nd      <= w_nd;
        r_stop    <= control.stop;
        r_par_on  <= w_par_on;
        r_par_bit <= w_par_bit;
        r_cnt     <= '0;
        r_bit     <= '0;
        r_sbit    <= 1'b0;
      end else if (r_state != IDLE) begin
        if (w_div_end) begin
          r_cnt <= '0;
          if (r_state == DATA) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 5'd1;
          end
          if (r_state == STOP) r_sbit <= 1'b1;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 9; maximum data bits per frame, range 5..16.
REQ-002 SHALL have parameter DIV_W, default 16; width of baud divisor.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; TX FIFO entries, power of 2, at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port control  input  tx_ctrl_t  fields: br_div[DIV_W], len[5], stop[1], par[2], en[1].
REQ-007 SHALL have port wr_data  input  DATA_W  word to transmit.
REQ-008 SHALL have port wr_valid  input  1  write request.
REQ-009 SHALL have port wr_ready  output  1  FIFO can accept a word.
REQ-010 SHALL have port tx  output  1  serial line; idles high.
REQ-011 SHALL have port idle  output  1  FSM in IDLE and FIFO empty.
REQ-012 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-013 SHALL accept a write on any edge where wr_valid && wr_ready; wr_ready = (level != FIFO_DEPTH).
REQ-014 SHALL drop writes while full and SHALL leave FIFO contents and level unchanged.
REQ-015 SHALL update level correctly on simultaneous push and pop, with the net change being 0.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL transition IDLE->START, pop one word, and latch control when FIFO non-empty and en=1.
REQ-018 SHALL drive tx=0 starting on the edge after the accepting edge when a word is written into an empty FIFO while IDLE with en=1.
REQ-019 SHALL hold each bit for max(br_div,1) clk cycles, counted by an internal DIV_W counter.
REQ-020 SHALL send data LSB first with bit count Nd = clamp(len, 5, DATA_W); bits above Nd SHALL be ignored.
REQ-021 SHALL send 1 stop bit when latched stop=0 and 2 stop bits when stop=1, with tx=1.
REQ-022 SHALL go STOP->START directly at the end of the stop bits if the FIFO is non-empty and en=1, leaving no idle gap; otherwise SHALL go STOP->IDLE.
REQ-023 SHALL not alter a frame in flight on changes to control or en; en=0 only blocks the next frame start.
REQ-024 SHALL drive tx=1 in IDLE.

Reset
REQ-025 SHALL, while rst_n=0 at an edge, set FSM=IDLE, tx=1, FIFO empty, level=0, wr_ready=1, idle=1, and clear counters.
REQ-026 SHALL abort a frame in progress on reset mid-frame, with tx=1 from the reset edge and queued words discarded.

Configuration
REQ-027 SHALL, with UART_TX_PARITY_EN defined, send a parity bit in PARITY after the data bits: par=1 even, par=2 odd, par=0/3 none (state skipped).
REQ-028 SHALL, without UART_TX_PARITY_EN, ignore par and never enter PARITY; the frame is start+data+stop.

Structure
REQ-029 SHALL place tx_ctrl_t and the FSM state enum tx_state_t in shared package data_types_pkg.
REQ-030 SHALL implement the FIFO as sub-module uart_tx_fifo (params DATA_W, FIFO_DEPTH; push/pop/level/full/empty).

Verification
REQ-031 SHALL verify: br_div=4, len=8, stop=0, en=1, write 0x08E -> tx 0,0,1,1,1,0,0,0,1,1, each bit 4 cycles; frame 40 cycles; then idle=1.
REQ-032 SHALL verify: len=9, write 0x1FE -> 9 data bits 0,1,1,1,1,1,1,1,1 then stop; len=8 with 0x1FE -> only 0xFE sent.
REQ-033 SHALL verify: stop=1, br_div=4 -> tx high 8 cycles after data; br_div=0 -> each bit 1 cycle.
REQ-034 SHALL verify: FIFO_DEPTH=4, en=0, 5 back-to-back writes -> 4 accepted, level=4, wr_ready=0; set en=1 -> 4 frames back-to-back with no idle cycle between them.
REQ-035 SHALL verify: UART_TX_PARITY_EN, len=8, write 0x81 -> parity bit 0 when par=1, parity bit 1 when par=2.
REQ-036 SHALL verify: rst_n=0 mid-DATA with 2 words queued -> tx=1 at next edge, level=0, idle=1, no further frames.
